// File: rtl/corelet_ctrl.sv
// corelet_ctrl
// Sequences one tile through the corelet: kernel words are streamed from the
// activation SRAM into L0, loaded into the PE array, activations are streamed
// into L0 and executed, then the output FIFO is drained into the psum SRAM.
//
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   start               one-cycle tile request, only honoured in IDLE
//   len                 activation vector count, latched on accepted start
//   kbase, abase        kernel / activation SRAM base addresses, latched on start
//   ofifo_valid         output FIFO holds at least one entry
//   inst                34-bit corelet instruction word
//   xmem_rd, xmem_addr  activation SRAM read enable / address
//   pmem_wr, pmem_addr  psum SRAM write enable / address
//   busy, done          tile in progress / one-cycle completion pulse
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic [addr_bw-1:0] kbase,
  input  logic [addr_bw-1:0] abase,
  input  logic               ofifo_valid,
  output logic [33:0]        inst,
  output logic               xmem_rd,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               pmem_wr,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = len_bw + 1;
  localparam logic [CNT_W-1:0] ROW_C    = CNT_W'(row);
  localparam logic [CNT_W-1:0] KLD_LAST = CNT_W'(row + col - 1);

  typedef enum logic [2:0] {IDLE, KW_L0, K_LD, AW_L0, EXEC, DRAIN, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [len_bw-1:0]  len_q;
  logic [addr_bw-1:0] kbase_q, abase_q;
  logic [CNT_W-1:0]   len_e;
  logic               accept;
  logic               rd_n;
  logic               xrd_n;
  logic [addr_bw-1:0] xaddr_n;
  logic [1:0]         mac_op_n;
  logic               l0_wr_n, l0_rd_n;

  // Next-state decode. cnt counts cycles inside a state and is cleared on
  // every entry; in DRAIN it instead counts the OFIFO reads issued so far.
  // All outputs below are registered from the next state/count so that each
  // output lines up with the state the FSM is actually in that cycle.
  always_comb begin
    accept   = (state == IDLE) && start;
    len_e    = {1'b0, len_q};
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    rd_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) state_n = KW_L0;
      end
      KW_L0: begin
        if (cnt == ROW_C) begin
          state_n = K_LD;
          cnt_n   = '0;
        end
      end
      K_LD: begin
        if (cnt == KLD_LAST) begin
          state_n = (len_q == '0) ? DONE : AW_L0;
          cnt_n   = '0;
        end
      end
      AW_L0: begin
        if (cnt == len_e) begin
          state_n = EXEC;
          cnt_n   = '0;
        end
      end
      EXEC: begin
        if (cnt == len_e - 1'b1) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end
      end
      DRAIN: begin
        cnt_n = cnt;
        // The final psum write is the one seen after all reads are issued
        // and no read is still in flight on inst[6].
        if (pmem_wr && !inst[6] && (cnt == len_e)) begin
          state_n = DONE;
          cnt_n   = '0;
        end else if (ofifo_valid && (cnt < len_e)) begin
          rd_n  = 1'b1;
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // L0 fill phases: SRAM read for the first N counts, L0 write one cycle
    // later to cover the SRAM read latency.
    xrd_n    = ((state_n == KW_L0) && (cnt_n < ROW_C)) ||
               ((state_n == AW_L0) && (cnt_n < len_e));
    xaddr_n  = (state_n == AW_L0) ? abase_q + addr_bw'(cnt_n)
                                  : (accept ? kbase : kbase_q) + addr_bw'(cnt_n);
    l0_wr_n  = ((state_n == KW_L0) || (state_n == AW_L0)) && (cnt_n != '0);
    l0_rd_n  = (state_n == K_LD) || (state_n == EXEC);
    mac_op_n = 2'b00;
    if ((state_n == K_LD) && (cnt_n < ROW_C)) mac_op_n = 2'b01;
    if (state_n == EXEC) mac_op_n = 2'b10;
  end

  // State, latched tile parameters and every output register. The SFP
  // accumulate bit and the psum write both trail the OFIFO read by a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      kbase_q   <= '0;
      abase_q   <= '0;
      inst      <= '0;
      xmem_rd   <= 1'b0;
      xmem_addr <= '0;
      pmem_wr   <= 1'b0;
      pmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        len_q   <= len;
        kbase_q <= kbase;
        abase_q <= abase;
      end
      xmem_rd <= xrd_n;
      if (xrd_n) xmem_addr <= xaddr_n;
      inst    <= {inst[6], 26'b0, rd_n, 2'b00, l0_rd_n, l0_wr_n, mac_op_n};
      pmem_wr <= inst[6];
      if (accept)       pmem_addr <= '0;
      else if (pmem_wr) pmem_addr <= pmem_addr + 1'b1;
      busy <= (state_n != IDLE);
      done <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl
// Scoreboard bench for corelet_ctrl: each tile request pushes the expected
// SRAM addresses, instruction words and psum addresses into queues, and an
// independent monitor pops and compares whenever the DUT presents them.
module tb_corelet_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int LW  = 8;
  localparam logic [33:0] ALLOWED = 34'h2_0000_004F;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] len;
  logic [AW-1:0] kbase, abase;
  logic          ofifo_valid = 1'b0;
  logic [33:0]   inst;
  logic          xmem_rd;
  logic [AW-1:0] xmem_addr;
  logic          pmem_wr;
  logic [AW-1:0] pmem_addr;
  logic          busy, done;

  int n_vec = 0;
  int n_err = 0;
  int mode = 0;
  int tog_ph = 0;
  int done_cnt = 0;
  int busy_len = 0;
  int exp_busy = 0;
  int tiles = 0;
  int exp_x[$];
  int exp_i[$];
  int exp_p[$];
  logic last_ofifo = 1'b0;
  logic prev6 = 1'b0;

  corelet_ctrl #(.row(ROW), .col(COL), .addr_bw(AW), .len_bw(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .kbase(kbase),
    .abase(abase), .ofifo_valid(ofifo_valid), .inst(inst), .xmem_rd(xmem_rd),
    .xmem_addr(xmem_addr), .pmem_wr(pmem_wr), .pmem_addr(pmem_addr),
    .busy(busy), .done(done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycles a tile occupies while busy when the OFIFO is always valid.
  function automatic int expBusy(input int l);
    if (l == 0) return 2 * ROW + COL + 2;
    return 2 * ROW + COL + 3 * l + 5;
  endfunction

  // OFIFO valid generator: always valid, a 1,0,0 toggle, or random.
  always @(negedge clk) begin
    case (mode)
      0: ofifo_valid = 1'b1;
      1: begin
        ofifo_valid = (tog_ph == 0);
        tog_ph = (tog_ph + 1) % 3;
      end
      default: ofifo_valid = 1'($urandom_range(0, 1));
    endcase
  end

  // Remember the valid seen by the DUT at each rising edge.
  always @(posedge clk) last_ofifo = ofifo_valid;

  // Monitor: pops expectations as the DUT presents reads, instructions and
  // writes, and checks the trailing accumulate/write relation every cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev6 = 1'b0;
      busy_len = 0;
    end else begin
      checkOutput("inst_reserved_bits", inst & ~ALLOWED, 0);
      checkOutput("inst33_trails_read", inst[33], prev6);
      checkOutput("pmem_wr_trails_read", pmem_wr, prev6);
      if (inst[6]) checkOutput("ofifo_read_valid", last_ofifo, 1);
      if (xmem_rd) begin
        if (exp_x.size() == 0) checkOutput("xmem_rd_unexpected", xmem_rd, 0);
        else checkOutput("xmem_addr", xmem_addr, exp_x.pop_front());
      end
      if (inst[3:0] != 4'h0) begin
        if (exp_i.size() == 0) checkOutput("inst_unexpected", inst[3:0], 0);
        else checkOutput("inst_low", inst[3:0], exp_i.pop_front());
      end
      if (pmem_wr) begin
        if (exp_p.size() == 0) checkOutput("pmem_wr_unexpected", pmem_wr, 0);
        else checkOutput("pmem_addr", pmem_addr, exp_p.pop_front());
      end
      if (busy) busy_len++;
      if (done) begin
        done_cnt++;
        checkOutput("busy_in_done", busy, 1);
        checkOutput("xmem_reads_missing", exp_x.size(), 0);
        checkOutput("inst_words_missing", exp_i.size(), 0);
        checkOutput("pmem_writes_missing", exp_p.size(), 0);
        if (exp_busy > 0) checkOutput("tile_cycles", busy_len, exp_busy);
      end
      if (!busy) busy_len = 0;
      prev6 = inst[6];
    end
  end

  // Issue one tile and queue everything the reference model says it produces.
  task automatic applyStimulus(input int l, input int kb, input int ab, input int ebusy);
    @(negedge clk);
    for (int i = 0; i < ROW; i++) exp_x.push_back((kb + i) % (1 << AW));
    for (int i = 0; i < l; i++)   exp_x.push_back((ab + i) % (1 << AW));
    for (int i = 0; i < ROW; i++) exp_i.push_back(4'h4);
    for (int i = 0; i < ROW; i++) exp_i.push_back(4'h9);
    for (int i = 0; i < COL; i++) exp_i.push_back(4'h8);
    for (int i = 0; i < l; i++)   exp_i.push_back(4'h4);
    for (int i = 0; i < l; i++)   exp_i.push_back(4'hA);
    for (int i = 0; i < l; i++)   exp_p.push_back(i);
    exp_busy = ebusy;
    tiles++;
    start = 1'b1;
    len   = LW'(l);
    kbase = AW'(kb);
    abase = AW'(ab);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone();
    int k;
    k = 0;
    while (done_cnt < tiles && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < tiles) checkOutput("done_timeout", done_cnt, tiles);
    repeat (3) @(negedge clk);
    checkOutput("done_pulse_count", done_cnt, tiles);
    checkOutput("busy_after_done", busy, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_inst"}, inst, 0);
    checkOutput({tag, "_xmem_rd"}, xmem_rd, 0);
    checkOutput({tag, "_xmem_addr"}, xmem_addr, 0);
    checkOutput({tag, "_pmem_wr"}, pmem_wr, 0);
    checkOutput({tag, "_pmem_addr"}, pmem_addr, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  // Main stimulus sequence.
  initial begin
    reset = 1'b1;
    start = 1'b0;
    len   = '0;
    kbase = '0;
    abase = '0;
    mode  = 0;
    repeat (3) @(negedge clk);
    checkAllZero("reset_state");
    reset = 1'b0;

    $display("[TB] basic tile len=4");
    applyStimulus(4, 0, 16, expBusy(4));
    waitDone();

    $display("[TB] len=0 tile");
    applyStimulus(0, 33, 700, expBusy(0));
    waitDone();

    $display("[TB] toggling ofifo_valid len=3");
    mode = 1;
    applyStimulus(3, 64, 128, 0);
    waitDone();
    mode = 0;

    $display("[TB] start during EXEC is ignored");
    applyStimulus(6, 50, 300, expBusy(6));
    repeat (33) @(negedge clk);
    start = 1'b1;
    len   = 8'd2;
    kbase = 11'd7;
    abase = 11'd9;
    @(negedge clk);
    start = 1'b0;
    waitDone();

    $display("[TB] reset mid AW_L0");
    applyStimulus(5, 100, 200, expBusy(5));
    repeat (27) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkAllZero("mid_reset");
    exp_x.delete();
    exp_i.delete();
    exp_p.delete();
    tiles--;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(4, 10, 20, expBusy(4));
    waitDone();

    $display("[TB] address wrap abase=2040 len=10");
    applyStimulus(10, 2044, 2040, expBusy(10));
    waitDone();

    $display("[TB] random tiles");
    mode = 2;
    for (int t = 0; t < 6; t++) begin
      applyStimulus(int'($urandom_range(0, 12)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 2047)), 0);
      waitDone();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
